// File: rtl/sr_input_conditioner.sv
// Synchronises, debounces and de-conflicts two push-buttons into the S/R inputs of an SR latch.
// Define SR_PULSE_OUT_EN for one-cycle S/R pulses per accepted press; the default build gives level outputs.
module sr_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_in,
  input  logic reset_in,
  output logic S,
  output logic R,
  output logic conflict
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_s_p0, sync_r_p0;
  logic                   sync_s, sync_r;
  logic [CNT_W-1:0]       cnt_s_p1, cnt_r_p1, cnt_s_nxt, cnt_r_nxt;
  logic                   db_s, db_r, db_s_nxt, db_r_nxt;
  logic                   s_nxt, r_nxt;

  // Returns {db, counter} for the next cycle; the counter restarts on any agreement,
  // so only an unbroken run of DEBOUNCE_CYCLES disagreements flips db.
  function automatic logic [CNT_W:0] debounce_next(input logic sync, input logic db,
                                                   input logic [CNT_W-1:0] cnt);
    if (sync == db)
      return {db, {CNT_W{1'b0}}};
    else if (cnt == CNT_LAST)
      return {sync, {CNT_W{1'b0}}};
    else
      return {db, cnt + 1'b1};
  endfunction

  assign sync_s = sync_s_p0[SYNC_STAGES-1];
  assign sync_r = sync_r_p0[SYNC_STAGES-1];

  always_comb begin
    {db_s_nxt, cnt_s_nxt} = debounce_next(sync_s, db_s, cnt_s_p1);
    {db_r_nxt, cnt_r_nxt} = debounce_next(sync_r, db_r, cnt_r_p1);
  end

  // Stage p0: synchroniser chains; stage p1: debounce counters and accepted values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s_p0 <= '0;
      sync_r_p0 <= '0;
      cnt_s_p1  <= '0;
      cnt_r_p1  <= '0;
      db_s      <= 1'b0;
      db_r      <= 1'b0;
    end else begin
      sync_s_p0 <= {sync_s_p0[SYNC_STAGES-2:0], set_in};
      sync_r_p0 <= {sync_r_p0[SYNC_STAGES-2:0], reset_in};
      cnt_s_p1  <= cnt_s_nxt;
      cnt_r_p1  <= cnt_r_nxt;
      db_s      <= db_s_nxt;
      db_r      <= db_r_nxt;
    end
  end

`ifdef SR_PULSE_OUT_EN
  logic db_s_p2, db_r_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_s_p2 <= 1'b0;
      db_r_p2 <= 1'b0;
    end else begin
      db_s_p2 <= db_s;
      db_r_p2 <= db_r;
    end
  end

  // A rise seen while the other channel is held is lost; it does not fire on release.
  always_comb begin
    s_nxt = db_s & ~db_s_p2 & ~db_r;
    r_nxt = db_r & ~db_r_p2 & ~db_s;
  end
`else
  always_comb begin
    s_nxt = db_s & ~db_r;
    r_nxt = db_r & ~db_s;
  end
`endif

  // Stage p2: registered latch drive; S and R are mutually exclusive by construction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S        <= 1'b0;
      R        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      S        <= s_nxt;
      R        <= r_nxt;
      conflict <= db_s & db_r;
    end
  end

endmodule
